// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, EX redirect flushes,
// data-memory handshake with whole-pipe freeze, perf counters and timeout fault.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [2:0]       ID_ValidReg,
  input  logic             ID_MemWrite,
  input  logic [4:0]       EX_rd,
  input  logic [2:0]       EX_ValidReg,
  input  logic             EX_MemRead,
  input  logic             EX_redirect,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_sel,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             stall_MEM,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic             flush_WB,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state, state_next;
  logic [15:0] wait_cnt, wait_cnt_next;
  logic        mem_busy, lu, freeze, redirect_go, lu_go;

  // rd-valid of the ID instruction and rs-used bits of EX play no part here.
  logic unused_bits;
  assign unused_bits = &{1'b0, ID_ValidReg[0], EX_ValidReg[2:1]};

  assign mem_busy = MEM_MemRead | MEM_MemWrite;

  // A store depending only through rs2 picks the value up by WB->MEM forwarding.
  assign lu = EX_MemRead && EX_ValidReg[0] && (EX_rd != 5'd0) &&
              ((ID_ValidReg[1] && (ID_rs1 == EX_rd)) ||
               (ID_ValidReg[2] && (ID_rs2 == EX_rd) && !ID_MemWrite));

  assign freeze = (state == FAULT) ||
                  (!dmem_ready && ((state == RUN && mem_busy) || state == MEM_WAIT));

  assign redirect_go = !freeze && EX_redirect;
  assign lu_go       = !freeze && !EX_redirect && lu;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // NOTE: every variable assigned in a combinational block gets a default first,
  // otherwise paths that skip the assignment infer latches.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      RUN: begin
        if (mem_busy && !dmem_ready) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt >= TIMEOUT_W) begin
          state_next = FAULT;
        end else begin
          wait_cnt_next = wait_cnt + 16'd1;
        end
      end
      default: state_next = state;
    endcase
  end

  // The request pulses only from RUN; a release cycle in MEM_WAIT belongs to the
  // instruction just served, so the next MEM occupant is requested a cycle later.
  always_comb begin
    dmem_req  = 1'b0;
    pc_sel    = 1'b0;
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MEM = 1'b0;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    flush_WB  = 1'b0;
    if (!rst) begin
      dmem_req  = (state == RUN) && mem_busy;
      pc_sel    = redirect_go;
      stall_IF  = freeze || lu_go;
      stall_ID  = freeze || lu_go;
      stall_EX  = freeze;
      stall_MEM = freeze;
      flush_ID  = redirect_go;
      flush_EX  = redirect_go || lu_go;
      flush_WB  = freeze;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
      mem_fault   <= 1'b0;
    end else begin
      if (stall_IF) stall_count <= stall_count + CNT_W'(1);
      if (pc_sel)   flush_count <= flush_count + CNT_W'(1);
      if (state_next == FAULT) mem_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan steps followed by
// randomized traffic compared against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       ID_rs1, ID_rs2, EX_rd;
  logic [2:0]       ID_ValidReg, EX_ValidReg;
  logic             ID_MemWrite, EX_MemRead, EX_redirect;
  logic             MEM_MemRead, MEM_MemWrite, dmem_ready;
  logic             dmem_req, pc_sel, stall_IF, stall_ID, stall_EX, stall_MEM;
  logic             flush_ID, flush_EX, flush_WB, mem_fault;
  logic [CNT_W-1:0] stall_count, flush_count;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_ValidReg(ID_ValidReg), .ID_MemWrite(ID_MemWrite),
    .EX_rd(EX_rd), .EX_ValidReg(EX_ValidReg), .EX_MemRead(EX_MemRead), .EX_redirect(EX_redirect),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_sel(pc_sel),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
    .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_WB(flush_WB),
    .mem_fault(mem_fault), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  logic [8:0] dut_comb;
  assign dut_comb = {dmem_req, pc_sel, stall_IF, stall_ID, stall_EX, stall_MEM,
                     flush_ID, flush_EX, flush_WB};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the memory access is either idle, outstanding for some
  // number of cycles, or has given up for good.
  bit          m_waiting = 1'b0;
  bit          m_fault   = 1'b0;
  int          m_wait    = 0;
  logic [31:0] m_stall   = '0;
  logic [31:0] m_flush   = '0;
  logic [8:0]  exp_comb;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  // Expected control word from the hazard rules, ordered like dut_comb.
  task automatic model_comb(output logic [8:0] e);
    bit busy, dep, held, go_redirect, go_bubble, req;
    e = '0;
    if (rst) return;
    busy = MEM_MemRead || MEM_MemWrite;
    dep  = EX_MemRead && EX_ValidReg[0] && EX_rd != 0 &&
           ((ID_ValidReg[1] && ID_rs1 == EX_rd) ||
            (ID_ValidReg[2] && ID_rs2 == EX_rd && !ID_MemWrite));
    if (m_fault)        held = 1'b1;
    else if (m_waiting) held = !dmem_ready;
    else                held = busy && !dmem_ready;
    req         = !m_fault && !m_waiting && busy;
    go_redirect = !held && EX_redirect;
    go_bubble   = !held && !EX_redirect && dep;
    e[8] = req;
    e[7] = go_redirect;
    e[6] = held || go_bubble;
    e[5] = held || go_bubble;
    e[4] = held;
    e[3] = held;
    e[2] = go_redirect;
    e[1] = go_redirect || go_bubble;
    e[0] = held;
  endtask

  task automatic settle(input string tag);
    #2;
    model_comb(exp_comb);
    check({tag, "/ctrl"}, 64'(dut_comb), 64'(exp_comb));
  endtask

  task automatic tick(input string tag);
    if (rst) begin
      m_waiting = 1'b0; m_fault = 1'b0; m_wait = 0; m_stall = '0; m_flush = '0;
    end else begin
      m_stall = m_stall + 32'(exp_comb[6]);
      m_flush = m_flush + 32'(exp_comb[7]);
      if (!m_fault) begin
        if (m_waiting) begin
          if (dmem_ready)             m_waiting = 1'b0;
          else if (m_wait == TIMEOUT) begin m_fault = 1'b1; m_waiting = 1'b0; end
          else                        m_wait++;
        end else if ((MEM_MemRead || MEM_MemWrite) && !dmem_ready) begin
          m_waiting = 1'b1;
          m_wait    = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check({tag, "/stall_count"}, 64'(stall_count), 64'(m_stall));
    check({tag, "/flush_count"}, 64'(flush_count), 64'(m_flush));
    check({tag, "/mem_fault"},   64'(mem_fault),   64'(m_fault));
  endtask

  task automatic cycle(input string tag);
    settle(tag);
    tick(tag);
  endtask

  task automatic set_idle();
    ID_rs1 = '0; ID_rs2 = '0; ID_ValidReg = '0; ID_MemWrite = 1'b0;
    EX_rd = '0; EX_ValidReg = '0; EX_MemRead = 1'b0; EX_redirect = 1'b0;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    cycle("reset");
    rst = 1'b0;
  endtask

  task automatic load_x5_in_ex();
    EX_MemRead = 1'b1; EX_ValidReg = 3'b001; EX_rd = 5'd5;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset forces every control output low even with hazards present.
    MEM_MemRead = 1'b1; EX_redirect = 1'b1; load_x5_in_ex();
    ID_rs1 = 5'd5; ID_ValidReg = 3'b011;
    settle("rst_hold");
    check("rst_outputs_zero", 64'(dut_comb), 64'd0);
    tick("rst_hold");
    check("rst_stall_count", 64'(stall_count), 64'd0);
    check("rst_mem_fault", 64'(mem_fault), 64'd0);
    rst = 1'b0;

    // Load-use: one bubble, then the load moves to MEM and nothing stalls.
    do_reset();
    load_x5_in_ex(); ID_rs1 = 5'd5; ID_ValidReg = 3'b011;
    settle("lu");
    check("lu_stall_bits", 64'({stall_IF, stall_ID, flush_EX, stall_EX}), 64'(4'b1110));
    tick("lu");
    check("lu_stall_count", 64'(stall_count), 64'd1);
    set_idle(); MEM_MemRead = 1'b1; dmem_ready = 1'b1;
    settle("lu_after");
    check("lu_after_no_stall", 64'(stall_IF), 64'd0);
    tick("lu_after");
    check("lu_after_stall_count", 64'(stall_count), 64'd1);

    // Store needing the load only through rs2, and x0 dependencies, never stall.
    do_reset();
    load_x5_in_ex(); ID_rs1 = 5'd7; ID_rs2 = 5'd5; ID_ValidReg = 3'b111; ID_MemWrite = 1'b1;
    settle("store_rs2");
    check("store_rs2_no_stall", 64'(stall_IF), 64'd0);
    tick("store_rs2");
    set_idle(); EX_MemRead = 1'b1; EX_ValidReg = 3'b001; EX_rd = 5'd0;
    ID_rs1 = 5'd0; ID_ValidReg = 3'b011;
    settle("x0");
    check("x0_no_stall", 64'(stall_IF), 64'd0);
    tick("x0");

    // Redirect wins over a simultaneous load-use.
    do_reset();
    load_x5_in_ex(); ID_rs1 = 5'd5; ID_ValidReg = 3'b011; EX_redirect = 1'b1;
    settle("redir");
    check("redir_bits", 64'({pc_sel, flush_ID, flush_EX, stall_IF}), 64'(4'b1110));
    tick("redir");
    check("redir_flush_count", 64'(flush_count), 64'd1);

    // Memory wait: request pulse only on the first cycle, release on the fourth.
    do_reset();
    MEM_MemRead = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dmem_ready = (k == 3);
      settle("wait");
      check("wait_req", 64'(dmem_req), 64'(k == 0));
      check("wait_freeze", 64'({stall_IF, stall_MEM, flush_WB}), (k < 3) ? 64'h7 : 64'h0);
      tick("wait");
    end
    check("wait_stall_count", 64'(stall_count), 64'd3);

    // Zero-wait accesses back to back each get a fresh request and no stall.
    do_reset();
    MEM_MemWrite = 1'b1; dmem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle("zero_wait");
      check("zero_wait_req_stall", 64'({dmem_req, stall_IF, stall_MEM}), 64'(3'b100));
      tick("zero_wait");
    end

    // Ready arriving exactly at the timeout count releases without a fault.
    do_reset();
    MEM_MemRead = 1'b1;
    for (int k = 0; k < 5; k++) begin
      dmem_ready = (k == 4);
      cycle("edge_release");
    end
    check("edge_release_no_fault", 64'(mem_fault), 64'd0);

    // Timeout: fault after the wait budget, sticky and frozen, cleared by reset.
    do_reset();
    MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle("timeout");
      check("timeout_fault_edge", 64'(mem_fault), 64'(k == 4));
    end
    dmem_ready = 1'b1; EX_redirect = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle("fault_hold");
      check("fault_frozen", 64'({dmem_req, pc_sel, stall_IF, stall_MEM, flush_WB}), 64'(5'b00111));
      tick("fault_hold");
      check("fault_sticky", 64'(mem_fault), 64'd1);
    end
    rst = 1'b1;
    settle("fault_rst");
    check("fault_rst_outputs", 64'(dut_comb), 64'd0);
    tick("fault_rst");
    rst = 1'b0;
    check("fault_rst_counts", 64'({stall_count, flush_count}), 64'd0);
    check("fault_rst_mem_fault", 64'(mem_fault), 64'd0);

    // Reset mid-wait: a late ready afterwards is ignored.
    do_reset();
    MEM_MemRead = 1'b1;
    cycle("midwait_enter");
    cycle("midwait_hold");
    rst = 1'b1;
    cycle("midwait_rst");
    rst = 1'b0;
    set_idle(); dmem_ready = 1'b1;
    settle("midwait_late_ready");
    check("midwait_late_ready_idle", 64'(dut_comb), 64'd0);
    tick("midwait_late_ready");

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 49) == 0);
      ID_rs1       = 5'($urandom_range(0, 3));
      ID_rs2       = 5'($urandom_range(0, 3));
      ID_ValidReg  = 3'($urandom_range(0, 7));
      ID_MemWrite  = 1'($urandom_range(0, 1));
      EX_rd        = 5'($urandom_range(0, 3));
      EX_ValidReg  = 3'($urandom_range(0, 7));
      EX_MemRead   = 1'($urandom_range(0, 1));
      EX_redirect  = ($urandom_range(0, 7) == 0);
      MEM_MemRead  = ($urandom_range(0, 3) == 0);
      MEM_MemWrite = ($urandom_range(0, 3) == 0);
      dmem_ready   = ($urandom_range(0, 9) < 6);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core; sits beside the forwarding unit.
- Handles the hazards forwarding cannot resolve:
  - load-use bubble insertion;
  - EX branch/jump redirect flush;
  - data-memory request handshake, with whole-pipe freeze while the request is outstanding.
- Also keeps stall/flush performance counters and a sticky memory-timeout fault.

Parameters:
TIMEOUT, 255, max cycles in MEM_WAIT before fault (1..65535)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ID_rs1  in  5  ID-stage source register 1
ID_rs2  in  5  ID-stage source register 2
ID_ValidReg  in  3  [0]=rd valid, [1]=rs1 used, [2]=rs2 used
ID_MemWrite  in  1  ID instruction is a store
EX_rd  in  5  EX-stage destination
EX_ValidReg  in  3  EX-stage register-valid bits
EX_MemRead  in  1  EX instruction is a load
EX_redirect  in  1  EX resolved taken branch/jump or mispredict
MEM_MemRead  in  1  MEM instruction is a load
MEM_MemWrite  in  1  MEM instruction is a store
dmem_ready  in  1  data memory completes the current access this cycle
dmem_req  out  1  single-cycle request pulse to data memory
pc_sel  out  1  select EX redirect target for PC
stall_IF  out  1  hold PC
stall_ID  out  1  hold IF/ID register
stall_EX  out  1  hold ID/EX register
stall_MEM  out  1  hold EX/MEM register
flush_ID  out  1  clear IF/ID to bubble
flush_EX  out  1  clear ID/EX to bubble
flush_WB  out  1  clear MEM/WB to bubble
mem_fault  out  1  sticky timeout fault
stall_count  out  CNT_W  cycles with stall_IF high
flush_count  out  CNT_W  redirect events

Behaviour:
- State register: RUN, MEM_WAIT, FAULT. Registered state, counters and mem_fault. All other outputs are combinational from state and inputs.
- Reset:
  - state=RUN; counters=0; mem_fault=0; wait counter=0.
  - All combinational outputs forced 0 while rst=1.
- Load-use detect (lu):
  - Fires when EX_MemRead & EX_ValidReg[0] & EX_rd!=0 and either:
    - ID_ValidReg[1] & ID_rs1==EX_rd; or
    - ID_ValidReg[2] & ID_rs2==EX_rd & !ID_MemWrite.
  - A store whose only dependency is rs2 gets WB->MEM forwarding, so it does not stall.
- mem_busy = MEM_MemRead | MEM_MemWrite.
- RUN:
  - If mem_busy:
    - dmem_req=1.
    - If dmem_ready in the same cycle: zero-wait access; stay RUN; evaluate redirect/lu normally.
    - Otherwise: stall_IF=stall_ID=stall_EX=stall_MEM=1 and flush_WB=1; next=MEM_WAIT; wait counter=1. Redirect/lu suppressed this cycle.
  - Redirect (not frozen): pc_sel=1, flush_ID=1, flush_EX=1; flush_count+1. Redirect has priority over lu; lu outputs are suppressed because the dependent instruction is squashed.
  - lu (no redirect, not frozen): stall_IF=stall_ID=1, flush_EX=1. Exactly one bubble, because the next cycle the load is in MEM and forwarding applies.
- MEM_WAIT:
  - dmem_req=0; dmem_req is never reissued while waiting.
  - If dmem_ready: release cycle.
    - No freeze; next=RUN; wait counter cleared.
    - Redirect/lu evaluated exactly as in RUN in this same cycle, because EX inputs were held stable.
    - Do not pulse dmem_req for the same MEM instruction. The new MEM instruction is requested starting next cycle.
  - Else: full freeze as above; wait counter+1.
    - When wait counter reaches TIMEOUT with dmem_ready still low: next=FAULT.
    - dmem_ready at count==TIMEOUT wins (release, no fault).
- FAULT:
  - mem_fault=1; full freeze (all stall_*=1, flush_WB=1); no dmem_req.
  - Held until rst.
- Counters:
  - stall_count increments every cycle stall_IF=1, including FAULT.
  - flush_count increments on each cycle pc_sel=1.
  - Both wrap modulo 2^CNT_W, no saturation.
- Reset mid-MEM_WAIT: returns to RUN next cycle; any outstanding dmem_ready arriving afterwards is ignored.

Test Plan:
- Load-use stall:
  - Stimulus: EX load x5 (EX_MemRead=1, EX_ValidReg=001, EX_rd=5); ID add with rs1=5 (ID_ValidReg=011).
  - Required: stall_IF=stall_ID=flush_EX=1 for exactly 1 cycle; stall_count=1.
- No stall for a store, or for x0:
  - Same setup with ID store, rs2=5, ID_MemWrite=1 → no stall.
  - EX_rd=0 with rs1=0 → no stall.
- Redirect over load-use:
  - EX_redirect=1 while the lu condition also holds.
  - Required: pc_sel=flush_ID=flush_EX=1, stall_IF=0; flush_count=1.
- Memory wait handshake:
  - MEM_MemRead=1, dmem_ready low 3 cycles then high.
  - Required: dmem_req pulse only in cycle 0; full freeze for cycles 0-2; release in cycle 3; stall_count=3.
- Zero-wait access:
  - MEM_MemWrite=1 with dmem_ready=1 in the same cycle.
  - Required: dmem_req=1, no stalls, state stays RUN.
- Timeout and reset:
  - TIMEOUT=4, dmem_ready held low.
  - Required: FAULT entered after 4 wait cycles; mem_fault=1 sticky with permanent freeze; rst=1 for one cycle clears all outputs and counters.
